// File: rtl/winograd_out_xform_stream_if.sv
// winograd_out_xform_stream_if: row-beat input and tile output handshake bundle
interface winograd_out_xform_stream_if #(
  parameter int DW = 32,
  parameter int OW = 32,
  parameter int CH = 1
);
  logic in_valid, in_ready, in_sof;
  logic [CH*4*DW-1:0] in_data;
  logic out_valid, out_ready, out_sat, err_sync;
  logic [CH*4*OW-1:0] out_data;
  logic [15:0] tile_cnt;
  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input in_ready, out_valid, out_data, out_sat, err_sync, tile_cnt
  );
  modport slave (
    input in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, err_sync, tile_cnt
  );
endinterface

// File: rtl/winograd_out_xform_stream.sv
// winograd_out_xform_stream: streaming Winograd F(2x2,3x3) output transform, one M row per beat
module winograd_out_xform_stream #(
  parameter int DW = 32,
  parameter int OW = 32,
  parameter int CH = 1,
  parameter int SHIFT = 0,
  parameter int SAT = 1
) (
  input logic clk,
  input logic rst,
  winograd_out_xform_stream_if.slave bus
);
  localparam int W = DW + 4;
  localparam int VW = (W + 1 > OW + 1) ? W + 1 : OW + 1;
  localparam logic signed [W:0] RND = ((W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [VW-1:0] MAXV = {{(VW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [VW-1:0] MINV = {{(VW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  logic [1:0] r, row;
  logic signed [DW+1:0] mm [CH][4];
  logic signed [DW+1:0] t0 [CH], t1 [CH];
  logic signed [W-1:0] acc [CH][4], acc_n [CH][4];
  logic [CH*4*OW-1:0] pd;
  logic [CH*4-1:0] pc;
  logic xfer_in, xfer_out, load;
  // returns {clipped, lane}; the extra headroom bit keeps the rounding add exact
  function automatic logic [OW:0] post(input logic signed [W-1:0] a);
    logic signed [W:0] s;
    logic signed [VW-1:0] v;
    logic hi, lo;
    s = ($signed({a[W-1], a}) + RND) >>> SHIFT;
    v = VW'(s);
    hi = SAT != 0 && v > MAXV;
    lo = SAT != 0 && v < MINV;
    return {hi | lo, hi ? MAXV[OW-1:0] : lo ? MINV[OW-1:0] : v[OW-1:0]};
  endfunction
  assign bus.in_ready = !(r == 2'd3 && bus.out_valid && !bus.out_ready);
  assign xfer_in = bus.in_valid && bus.in_ready;
  assign xfer_out = bus.out_valid && bus.out_ready;
  // a sof beat always restarts the tile as row 0
  assign row = bus.in_sof ? 2'd0 : r;
  assign load = xfer_in && row == 2'd3;
  always_comb begin
    pd = '0;
    pc = '0;
    for (int c = 0; c < CH; c++) begin
      for (int j = 0; j < 4; j++) mm[c][j] = (DW+2)'($signed(bus.in_data[(c*4+j)*DW +: DW]));
      t0[c] = mm[c][0] + mm[c][1] + mm[c][2];
      t1[c] = mm[c][1] - mm[c][2] - mm[c][3];
      acc_n[c][0] = row == 2'd0 ? W'(t0[c]) : row == 2'd3 ? acc[c][0] : acc[c][0] + W'(t0[c]);
      acc_n[c][1] = row == 2'd0 ? W'(t1[c]) : row == 2'd3 ? acc[c][1] : acc[c][1] + W'(t1[c]);
      acc_n[c][2] = row == 2'd0 ? '0 : row == 2'd1 ? acc[c][2] + W'(t0[c]) : acc[c][2] - W'(t0[c]);
      acc_n[c][3] = row == 2'd0 ? '0 : row == 2'd1 ? acc[c][3] + W'(t1[c]) : acc[c][3] - W'(t1[c]);
      for (int k = 0; k < 4; k++) {pc[c*4+k], pd[(c*4+k)*OW +: OW]} = post(acc_n[c][k]);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r <= 2'd0;
      acc <= '{default: '0};
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_sat <= 1'b0;
      bus.err_sync <= 1'b0;
      bus.tile_cnt <= 16'd0;
    end else begin
      if (xfer_in) begin
        r <= row + 2'd1;
        acc <= acc_n;
        if (bus.in_sof && r != 2'd0) bus.err_sync <= 1'b1;
      end
      if (load) begin
        bus.out_valid <= 1'b1;
        bus.out_data <= pd;
        bus.out_sat <= |pc;
      end else if (xfer_out) bus.out_valid <= 1'b0;
      if (xfer_out) bus.tile_cnt <= bus.tile_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_winograd_out_xform_stream.sv
// tb_winograd_out_xform_stream: directed checks of four lockstep configurations sharing one stimulus
module tb_winograd_out_xform_stream;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic vld = 1'b0, sof = 1'b0, ordy = 1'b1;
  int m [2][4];
  int tile [2][4][4];
  int checks = 0, errors = 0, cyc = 0, c0;
  always @(posedge clk) cyc <= cyc + 1;
  winograd_out_xform_stream_if #(.DW(32), .OW(32), .CH(2)) ia ();
  winograd_out_xform_stream_if #(.DW(16), .OW(16), .CH(1)) ib ();
  winograd_out_xform_stream_if #(.DW(16), .OW(16), .CH(1)) ic ();
  winograd_out_xform_stream_if #(.DW(32), .OW(32), .CH(1)) id ();
  winograd_out_xform_stream #(.DW(32), .OW(32), .CH(2), .SHIFT(0), .SAT(1)) da (.clk(clk), .rst(rst), .bus(ia));
  winograd_out_xform_stream #(.DW(16), .OW(16), .CH(1), .SHIFT(0), .SAT(1)) db (.clk(clk), .rst(rst), .bus(ib));
  winograd_out_xform_stream #(.DW(16), .OW(16), .CH(1), .SHIFT(0), .SAT(0)) dc (.clk(clk), .rst(rst), .bus(ic));
  winograd_out_xform_stream #(.DW(32), .OW(32), .CH(1), .SHIFT(2), .SAT(1)) dd (.clk(clk), .rst(rst), .bus(id));
  assign ia.in_valid = vld;
  assign ib.in_valid = vld;
  assign ic.in_valid = vld;
  assign id.in_valid = vld;
  assign ia.in_sof = sof;
  assign ib.in_sof = sof;
  assign ic.in_sof = sof;
  assign id.in_sof = sof;
  assign ia.out_ready = ordy;
  assign ib.out_ready = ordy;
  assign ic.out_ready = ordy;
  assign id.out_ready = ordy;
  always_comb begin
    ia.in_data = '0;
    ib.in_data = '0;
    ic.in_data = '0;
    id.in_data = '0;
    for (int j = 0; j < 4; j++) begin
      ia.in_data[j*32 +: 32] = m[0][j];
      ia.in_data[(4+j)*32 +: 32] = m[1][j];
      ib.in_data[j*16 +: 16] = 16'(m[0][j]);
      ic.in_data[j*16 +: 16] = 16'(m[0][j]);
      id.in_data[j*32 +: 32] = m[0][j];
    end
  end
  function automatic longint la(input int c, input int k);
    return longint'($signed(ia.out_data[(c*4+k)*32 +: 32]));
  endfunction
  function automatic longint lb(input int k);
    return longint'($signed(ib.out_data[k*16 +: 16]));
  endfunction
  function automatic longint lc(input int k);
    return longint'($signed(ic.out_data[k*16 +: 16]));
  endfunction
  function automatic longint ld(input int k);
    return longint'($signed(id.out_data[k*32 +: 32]));
  endfunction
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic check_a(input string tag, input int c, input longint y0, input longint y1, input longint y2, input longint y3);
    check({tag, "_y00"}, la(c, 0), y0);
    check({tag, "_y01"}, la(c, 1), y1);
    check({tag, "_y10"}, la(c, 2), y2);
    check({tag, "_y11"}, la(c, 3), y3);
  endtask
  // kinds: 0 zeros, 1 all ones, 2 only m[1][1]=5, 3 all 32767, 4 junk
  task automatic set_tile(input int c, input int kind);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        tile[c][r][j] = kind == 1 ? 1 : kind == 2 ? ((r == 1 && j == 1) ? 5 : 0) :
                        kind == 3 ? 32767 : kind == 4 ? 100 + r * 4 + j : 0;
  endtask
  task automatic beat(input int row, input logic s);
    int n = 0;
    logic ok;
    for (int c = 0; c < 2; c++) for (int j = 0; j < 4; j++) m[c][j] = tile[c][row][j];
    vld = 1'b1;
    sof = s;
    do begin
      @(negedge clk);
      ok = ia.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 40);
    if (!ok) check("beat_timeout", 0, 1);
    vld = 1'b0;
    sof = 1'b0;
  endtask
  task automatic send(input logic s0);
    for (int r = 0; r < 4; r++) beat(r, r == 0 ? s0 : 1'b0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", ia.out_valid, 0);
    check("rst_data", |ia.out_data, 0);
    check("rst_cnt", ia.tile_cnt, 0);
    check("rst_err", ia.err_sync, 0);
    check("rst_rdy", ia.in_ready, 1);
    rst = 1'b1;
    ordy = 1'b0;
    set_tile(0, 1);
    set_tile(1, 1);
    send(1'b1);
    check("t1_ov", ia.out_valid, 1);
    check_a("t1", 0, 9, -3, -3, 1);
    check("t1_sat", ia.out_sat, 0);
    check("t1_cnt0", ia.tile_cnt, 0);
    for (int k = 0; k < 4; k++) check("shift_lane", ld(k), k == 0 ? 2 : k == 3 ? 0 : -1);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    check("t1_cnt1", ia.tile_cnt, 1);
    check("t1_ov_clr", ia.out_valid, 0);
    set_tile(0, 2);
    send(1'b1);
    check_a("t2c0", 0, 5, 5, 5, 5);
    check_a("t2c1", 1, 9, -3, -3, 1);
    @(posedge clk);
    #1;
    check("t2_cnt", ia.tile_cnt, 2);
    set_tile(0, 3);
    set_tile(1, 3);
    send(1'b1);
    for (int k = 0; k < 4; k++) check("sat_lane", lb(k), (k == 0 || k == 3) ? 32767 : -32768);
    check("sat_flag", ib.out_sat, 1);
    for (int k = 0; k < 4; k++) check("wrap_lane", lc(k), k == 0 ? 32759 : k == 3 ? 32767 : -32765);
    check("wrap_flag", ic.out_sat, 0);
    check("wide_y00", la(0, 0), 294903);
    check("wide_sat", ia.out_sat, 0);
    @(posedge clk);
    #1;
    check("t3_cnt", ia.tile_cnt, 3);
    set_tile(0, 1);
    set_tile(1, 1);
    c0 = cyc;
    send(1'b1);
    check("b2b_ov_a", ia.out_valid, 1);
    check("b2b_a", la(0, 0), 9);
    set_tile(0, 2);
    send(1'b0);
    check("b2b_cycles", cyc - c0, 8);
    check("b2b_ov_b", ia.out_valid, 1);
    check("b2b_b", la(0, 0), 5);
    check("nosof_err", ia.err_sync, 0);
    check("b2b_cnt4", ia.tile_cnt, 4);
    @(posedge clk);
    #1;
    check("b2b_cnt5", ia.tile_cnt, 5);
    ordy = 1'b0;
    set_tile(0, 1);
    send(1'b1);
    set_tile(0, 2);
    fork
      send(1'b1);
      begin
        for (int k = 1; k <= 6; k++) begin
          @(posedge clk);
          #1;
          check("bp_ov", ia.out_valid, 1);
          check("bp_hold", la(0, 0), 9);
          check("bp_rdy", ia.in_ready, k < 3);
        end
        ordy = 1'b1;
      end
    join
    check("bp_ov_new", ia.out_valid, 1);
    check_a("bpc0", 0, 5, 5, 5, 5);
    check("bp_c1", la(1, 0), 9);
    check("bp_cnt6", ia.tile_cnt, 6);
    @(posedge clk);
    #1;
    check("bp_cnt7", ia.tile_cnt, 7);
    check("bp_ov_clr", ia.out_valid, 0);
    check("sync_pre", ia.err_sync, 0);
    set_tile(0, 4);
    set_tile(1, 4);
    beat(0, 1'b1);
    beat(1, 1'b0);
    set_tile(0, 2);
    set_tile(1, 1);
    beat(0, 1'b1);
    check("sync_err", ia.err_sync, 1);
    beat(1, 1'b0);
    beat(2, 1'b0);
    beat(3, 1'b0);
    check_a("syncc0", 0, 5, 5, 5, 5);
    check_a("syncc1", 1, 9, -3, -3, 1);
    @(posedge clk);
    #1;
    check("sync_cnt", ia.tile_cnt, 8);
    check("sync_sticky", ia.err_sync, 1);
    ordy = 1'b0;
    set_tile(0, 1);
    send(1'b1);
    set_tile(0, 4);
    set_tile(1, 4);
    beat(0, 1'b1);
    beat(1, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_ov", ia.out_valid, 0);
    check("mrst_data", |ia.out_data, 0);
    check("mrst_cnt", ia.tile_cnt, 0);
    check("mrst_err", ia.err_sync, 0);
    check("mrst_rdy", ia.in_ready, 1);
    rst = 1'b1;
    ordy = 1'b1;
    set_tile(0, 1);
    set_tile(1, 1);
    send(1'b1);
    check_a("post_rst", 0, 9, -3, -3, 1);
    check("post_rst_err", ia.err_sync, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
